// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core load/store
// port (requester 0) and the debug/DMA port (requester 1).
// Grants are combinational and responses arrive one cycle later.
// Accesses at word addresses >= DEPTH never write memory; they return err and zero data.
// Configuration macro DMEM_ARB_ROUND_ROBIN_EN: when defined, contention alternates
// between requesters; when undefined, requester 0 always wins contention.

module dmem_arbiter #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic in_range0;
  logic in_range1;
  logic pick0;

  assign in_range0 = (addr0 < DEPTH_W);
  assign in_range1 = (addr1 < DEPTH_W);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_grant = 1 means requester 1 was served most recently, so requester 0
  // wins the next contention; reset value lets requester 0 win first.
  logic last_grant;

  assign pick0 = last_grant;

  // Track the most recently granted requester; idle cycles leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end
`else
  // Fixed priority: requester 0 always wins contention.
  assign pick0 = 1'b1;
`endif

  // Pick at most one requester this cycle and steer its access onto the memory port
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || pick0)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      mem_a  = addr0;
      mem_wd = wdata0;
      mem_we = we0 & in_range0;
    end else if (gnt1) begin
      mem_a  = addr1;
      mem_wd = wdata1;
      mem_we = we1 & in_range1;
    end
  end

  // Register the one-cycle response for requester 0; rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      err0    <= 1'b0;
      rdata0  <= '0;
    end else begin
      rvalid0 <= gnt0;
      err0    <= gnt0 & ~in_range0;
      if (gnt0 && !in_range0) begin
        rdata0 <= '0;
      end else if (gnt0 && !we0) begin
        rdata0 <= mem_rd;
      end
    end
  end

  // Register the one-cycle response for requester 1; rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid1 <= 1'b0;
      err1    <= 1'b0;
      rdata1  <= '0;
    end else begin
      rvalid1 <= gnt1;
      err1    <= gnt1 & ~in_range1;
      if (gnt1 && !in_range1) begin
        rdata1 <= '0;
      end else if (gnt1 && !we1) begin
        rdata1 <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, hand-written reset sequence and
// random traffic for dmem_arbiter, checked against a transaction-level model.

module tb_dmem_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

  // Environment memory seen by the DUT, and the model's own copy
  logic [31:0] env_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  // Model state: who was served last and the response expected after each edge
  int          last_win;
  logic        exp_rv [2];
  logic        exp_er [2];
  logic [31:0] exp_rd [2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  g_rr;
    logic [1:0]  g_fp;
  } vec_t;

  vec_t vecs [16];

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Combinational read port; out-of-range addresses return junk the DUT must not pass on
  assign mem_rd = (mem_a < 32'(DEPTH)) ? env_mem[mem_a[AW-1:0]] : 32'hBAD0_BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Arbitration rule: a lone requester wins; contention goes to the other one
  // than last served (round-robin) or always to requester 0 (fixed priority).
  function automatic int model_pick(input logic r0, input logic r1);
    if (r0 && r1) return RR_EN ? ((last_win == 0) ? 1 : 0) : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    last_win  = 1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    exp_rd[0] = '0;   exp_rd[1] = '0;
  endtask

  // One cycle: drive at negedge, check grant/memory port, then check the response
  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               output logic [1:0] act_g, output int win);
    logic        cw, ew, w;
    logic [31:0] ca, cd, ea, ed, a, d;
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    win = model_pick(r0, r1);
    w = 1'b0; a = '0; d = '0;
    if (win == 0) begin w = w0; a = a0; d = d0; end
    if (win == 1) begin w = w1; a = a1; d = d1; end
    ea = a; ed = d; ew = w && (a < 32'(DEPTH));
    act_g = {gnt1, gnt0};
    checkOutput("gnt0", 32'(gnt0), 32'(win == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(win == 1));
    checkOutput("mem_a", mem_a, ea);
    checkOutput("mem_wd", mem_wd, ed);
    checkOutput("mem_we", 32'(mem_we), 32'(ew));
    cw = mem_we; ca = mem_a; cd = mem_wd;
    @(posedge clk);
    #1;
    if (cw) env_mem[ca[AW-1:0]] = cd;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    if (win >= 0) begin
      exp_rv[win] = 1'b1;
      if (a >= 32'(DEPTH)) begin
        exp_er[win] = 1'b1;
        exp_rd[win] = '0;
      end else if (!w) begin
        exp_rd[win] = ref_mem[a[AW-1:0]];
      end else begin
        ref_mem[a[AW-1:0]] = d;
      end
      last_win = win;
    end
    checkOutput("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    checkOutput("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    checkOutput("err0", 32'(err0), 32'(exp_er[0]));
    checkOutput("err1", 32'(err1), 32'(exp_er[1]));
    checkOutput("rdata0", rdata0, exp_rd[0]);
    checkOutput("rdata1", rdata1, exp_rd[1]);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return 32'($urandom_range(0, 15));
    if (r == 7) return 32'($urandom_range(DEPTH - 4, DEPTH - 1));
    if (r == 8) return 32'($urandom_range(DEPTH, DEPTH + 3));
    return $urandom;
  endfunction

  initial begin
    logic [1:0]  g;
    int          win;
    logic        pr0, pw0, pr1, pw1, hold0, hold1;
    logic [31:0] pa0, pd0, pa1, pd1;

    // Directed vectors: {req0 we0 addr0 wdata0, req1 we1 addr1 wdata1, grant RR, grant fixed}
    vecs[0]  = '{1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, 2'b01, 2'b01};
    vecs[1]  = '{1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, 2'b10, 2'b01};
    vecs[2]  = '{1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, 2'b01, 2'b01};
    vecs[3]  = '{1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, 2'b10, 2'b01};
    vecs[4]  = '{1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0, 2'b01, 2'b01};
    vecs[5]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 2'b10, 2'b10};
    vecs[6]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 2'b00};
    vecs[8]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd1024, 32'h12345678, 2'b10, 2'b10};
    vecs[10] = '{1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b01, 2'b01};
    vecs[11] = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1023, 32'd0, 2'b10, 2'b10};
    vecs[12] = '{1'b1, 1'b1, 32'd1023, 32'h0BADF00D, 1'b1, 1'b1, 32'd1023, 32'h11112222, 2'b01, 2'b01};
    vecs[13] = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd1023, 32'h11112222, 2'b10, 2'b10};
    vecs[14] = '{1'b1, 1'b0, 32'd1023, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b01, 2'b01};
    vecs[15] = '{1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 32'd6, 32'd0, 2'b10, 2'b01};

    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = pattern(i);
      ref_mem[i] = pattern(i);
    end
    model_reset();

    // Reset held with a write request pending: nothing may be granted
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hFFFF_FFFF;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd6; wdata1 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
    checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("rst_rvalid1", 32'(rvalid1), 32'd0);
    checkOutput("rst_err0", 32'(err0), 32'd0);
    checkOutput("rst_err1", 32'(err1), 32'd0);
    checkOutput("rst_rdata0", rdata0, 32'd0);
    checkOutput("rst_rdata1", rdata1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, g, win);
      checkOutput($sformatf("vec%0d_grant", i), 32'(g), 32'(RR_EN ? vecs[i].g_rr : vecs[i].g_fp));
    end
    checkOutput("word0_untouched", env_mem[0], pattern(0));

    // Reset arriving mid-cycle while a read by requester 0 is granted
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, g, win);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3; wdata0 = 32'd0;
    #1;
    checkOutput("midrst_pre_gnt0", 32'(gnt0), 32'd1);
    checkOutput("midrst_pre_rvalid0", 32'(rvalid0), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_gnt0", 32'(gnt0), 32'd0);
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_mem_a", mem_a, 32'd0);
    checkOutput("midrst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("midrst_rdata0", rdata0, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_hold_rvalid0", 32'(rvalid0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("postrst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("postrst_err0", 32'(err0), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, g, win);
    checkOutput("postrst_first_contention", 32'(g), 32'd1);

    // Random traffic; a requester holds its request until granted
    hold0 = 1'b0; hold1 = 1'b0;
    pr0 = 1'b0; pw0 = 1'b0; pa0 = '0; pd0 = '0;
    pr1 = 1'b0; pw1 = 1'b0; pa1 = '0; pd1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold0) begin
        pr0 = ($urandom_range(0, 2) != 0);
        pw0 = 1'($urandom_range(0, 1));
        pa0 = rand_addr();
        pd0 = $urandom;
      end
      if (!hold1) begin
        pr1 = ($urandom_range(0, 2) != 0);
        pw1 = 1'($urandom_range(0, 1));
        pa1 = rand_addr();
        pd1 = $urandom;
      end
      applyStimulus(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1, g, win);
      hold0 = pr0 && (win != 0);
      hold1 = pr1 && (win != 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
